// File: rtl/evict_wb_control.sv
// Control FSM for the single-entry eviction write buffer: decides when an evicted
// line is captured (load) and when it is written back to physical memory.
module evict_wb_control (
    input  logic clk,
    input  logic rst_n,
    input  logic write,
    input  logic pmem_read,
    input  logic pmem_resp,
    input  logic full,
    output logic load,
    output logic pmem_write
);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        HOLD      = 2'd1,
        WRITEBACK = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // load is gated by rst_n so that no capture is signalled while reset is held.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        pmem_write = 1'b0;
        case (state)
            EMPTY: begin
                if (write && !full) begin
                    load       = rst_n;
                    state_next = pmem_read ? HOLD : WRITEBACK;
                end
            end
            HOLD: begin
                if (!pmem_read) begin
                    state_next = WRITEBACK;
                end
            end
            WRITEBACK: begin
                // Demand reads arriving now wait; an in-flight write-back is never aborted.
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

endmodule

// File: tb/tb_evict_wb_control.sv
// Scoreboard bench for evict_wb_control: directed vectors push expected {load, pmem_write}
// per cycle; a negedge monitor pops and compares.
module tb_evict_wb_control;

    logic clk;
    logic rst_n;
    logic write;
    logic pmem_read;
    logic pmem_resp;
    logic full;
    logic load;
    logic pmem_write;

    typedef struct {
        string name;
        logic  load;
        logic  pw;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_pass;

    evict_wb_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .write      (write),
        .pmem_read  (pmem_read),
        .pmem_resp  (pmem_resp),
        .full       (full),
        .load       (load),
        .pmem_write (pmem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: {load,pmem_write} got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected entry per stimulus cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, {load, pmem_write}, {e.load, e.pw});
        end
    end

    task automatic step(input string name, input logic w, input logic r, input logic rs,
                        input logic f, input logic el, input logic ep);
        exp_t e;
        @(posedge clk);
        #1;
        write     = w;
        pmem_read = r;
        pmem_resp = rs;
        full      = f;
        e.name = name;
        e.load = el;
        e.pw   = ep;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        write     = 1'b1;
        pmem_read = 1'b0;
        pmem_resp = 1'b0;
        full      = 1'b0;
        #3;
        check("reset_outputs", {load, pmem_write}, 2'b00);
        #14;
        rst_n = 1'b1;
        write = 1'b0;
        #3;

        // Simple eviction: load, write-back for four cycles, response, idle.
        step("simple_load",   1, 0, 0, 0, 1, 0);
        step("simple_wb1",    0, 0, 0, 1, 0, 1);
        step("simple_wb2",    0, 0, 0, 1, 0, 1);
        step("simple_wb3",    0, 0, 0, 1, 0, 1);
        step("simple_resp",   0, 0, 1, 1, 0, 1);
        step("simple_empty",  0, 0, 0, 0, 0, 0);

        // Read priority: load into HOLD, wait for pmem_read to drop.
        step("prio_load",     1, 1, 0, 0, 1, 0);
        step("prio_hold1",    0, 1, 0, 1, 0, 0);
        step("prio_hold_wr",  1, 1, 0, 0, 0, 0);
        step("prio_read_off", 0, 0, 0, 1, 0, 0);
        step("prio_wb",       0, 0, 0, 1, 0, 1);
        step("prio_resp",     0, 0, 1, 1, 0, 1);
        step("prio_empty",    0, 0, 0, 0, 0, 0);

        // Busy buffer: write held through write-back, loads once back in EMPTY.
        step("busy_load",     1, 0, 0, 0, 1, 0);
        step("busy_wb_wr",    1, 0, 0, 1, 0, 1);
        step("busy_wb_wr2",   1, 0, 0, 1, 0, 1);
        step("busy_resp_wr",  1, 0, 1, 1, 0, 1);
        step("busy_reload",   1, 0, 0, 0, 1, 0);
        step("busy_wb",       0, 0, 0, 1, 0, 1);
        step("busy_resp",     0, 0, 1, 1, 0, 1);
        step("busy_empty",    0, 0, 0, 0, 0, 0);

        // No abort: pmem_read rises mid write-back.
        step("nabort_load",   1, 0, 0, 0, 1, 0);
        step("nabort_rd1",    0, 1, 0, 1, 0, 1);
        step("nabort_rd2",    0, 1, 0, 1, 0, 1);
        step("nabort_resp",   0, 1, 1, 1, 0, 1);
        step("nabort_empty",  0, 1, 0, 0, 0, 0);
        step("nabort_idle",   0, 0, 0, 0, 0, 0);

        // Spurious responses and a write while full in EMPTY.
        step("spur_empty",    0, 0, 1, 0, 0, 0);
        step("spur_empty2",   0, 0, 0, 0, 0, 0);
        step("empty_full_wr", 1, 0, 0, 1, 0, 0);
        step("empty_full_wr2",0, 0, 0, 0, 0, 0);
        step("spur_load",     1, 1, 0, 0, 1, 0);
        step("spur_hold",     0, 1, 1, 1, 0, 0);
        step("spur_hold2",    1, 1, 0, 0, 0, 0);
        step("spur_read_off", 0, 0, 0, 1, 0, 0);
        step("spur_wb",       0, 0, 1, 1, 0, 1);
        step("spur_done",     0, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a write-back.
        step("rst_load",      1, 0, 0, 0, 1, 0);
        step("rst_wb",        0, 0, 0, 1, 0, 1);
        @(negedge clk);
        #2;
        write = 1'b1;
        full  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_async_drop", {load, pmem_write}, 2'b00);
        @(posedge clk);
        #1;
        check("rst_held", {load, pmem_write}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        write = 1'b0;
        step("rst_after_idle", 0, 0, 0, 0, 0, 0);
        step("rst_after_load", 1, 0, 0, 0, 1, 0);
        step("rst_after_wb",   0, 0, 0, 1, 0, 1);
        step("rst_after_resp", 0, 0, 1, 1, 0, 1);
        step("rst_after_empty",0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        check("queue_drained", (exp_q.size() == 0) ? 2'b00 : 2'b11, 2'b00);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
